// File: rtl/spi_share_arbiter.sv
// Two-requester round-robin arbiter that shares one SPI master between the sobel and gcd engines.
// Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module spi_share_arbiter #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        req_i,
  input  logic [DATA_W-1:0] tx0_i,
  input  logic [DATA_W-1:0] tx1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              spi_start_o,
  output logic [DATA_W-1:0] spi_tx_o,
  output logic              spi_sel_o,
  input  logic              spi_done_i,
  input  logic [DATA_W-1:0] spi_rx_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP} state_t;

  state_t            state_reg, state_next;
  logic              owner_reg;
  logic              rr_last_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic              pick;
  logic              timeout_hit;
  logic              grant_now;

  // On a tie the requester that did not own the bus last time wins.
  always_comb begin
    pick = 1'b0;
    case (req_i)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~rr_last_reg;
      default: pick = 1'b0;
    endcase
  end

  assign grant_now = (state_reg == ST_IDLE) && (|req_i);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_reg;

  assign timeout_hit = (state_reg == ST_WAIT) && !spi_done_i &&
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 1'b1 : '0;
      if (state_reg == ST_WAIT && spi_done_i)
        timeout_reg <= 1'b0;
      else if (timeout_hit)
        timeout_reg <= 1'b1;
    end
  end

  assign err_o = (state_reg == ST_RESP) && timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (|req_i) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (spi_done_i || timeout_hit) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = 2'b00;
    done_o = 2'b00;
    if (grant_now && !reset_i)
      gnt_o[pick] = 1'b1;
    if (state_reg == ST_RESP)
      done_o[owner_reg] = 1'b1;
    spi_start_o = (state_reg == ST_START);
    busy_o      = (state_reg != ST_IDLE);
  end

  // Owner and its word are frozen at grant so the SPI side sees stable data until RESP.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_reg   <= 1'b0;
      rr_last_reg <= 1'b1;
      tx_reg      <= '0;
      rx_reg      <= '0;
    end else begin
      if (grant_now) begin
        owner_reg <= pick;
        tx_reg    <= pick ? tx1_i : tx0_i;
      end
      if (state_reg == ST_WAIT && spi_done_i)
        rx_reg <= spi_rx_i;
      else if (timeout_hit)
        rx_reg <= '1;
      if (state_reg == ST_RESP)
        rr_last_reg <= owner_reg;
    end
  end

  assign spi_tx_o  = tx_reg;
  assign spi_sel_o = owner_reg;
  assign rx_data_o = rx_reg;

endmodule

// File: tb/tb_spi_share_arbiter.sv
// Directed self-checking bench for spi_share_arbiter; define ARB_TIMEOUT_EN to exercise the watchdog.
module tb_spi_share_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_i;
  logic [15:0] tx0_i, tx1_i;
  logic [1:0]  gnt_o, done_o;
  logic [15:0] rx_data_o;
  logic        err_o, busy_o, spi_start_o, spi_sel_o;
  logic [15:0] spi_tx_o;
  logic        spi_done_i;
  logic [15:0] spi_rx_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  spi_share_arbiter #(.DATA_W(16), .TIMEOUT_CYC(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .tx0_i       (tx0_i),
    .tx1_i       (tx1_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .rx_data_o   (rx_data_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .spi_start_o (spi_start_o),
    .spi_tx_o    (spi_tx_o),
    .spi_sel_o   (spi_sel_o),
    .spi_done_i  (spi_done_i),
    .spi_rx_i    (spi_rx_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},   32'(gnt_o), 32'h0);
    check({tag, "_done"},  32'(done_o), 32'h0);
    check({tag, "_err"},   32'(err_o), 32'h0);
    check({tag, "_busy"},  32'(busy_o), 32'h0);
    check({tag, "_start"}, 32'(spi_start_o), 32'h0);
    check({tag, "_sel"},   32'(spi_sel_o), 32'h0);
    check({tag, "_tx"},    32'(spi_tx_o), 32'h0);
    check({tag, "_rx"},    32'(rx_data_o), 32'h0);
  endtask

  // One complete transfer starting in IDLE; returns one cycle after RESP.
  task automatic xfer(input string tag, input logic [1:0] req, input logic [1:0] exp_gnt,
                      input logic [15:0] exp_tx, input int wait_n, input logic [15:0] rx,
                      input bit hold);
    req_i = req;
    #1;
    check({tag, "_gnt"}, 32'(gnt_o), 32'(exp_gnt));
    step();
    if (!hold) req_i = 2'b00;
    #1;
    check({tag, "_start"}, 32'(spi_start_o), 32'h1);
    check({tag, "_sel"},   32'(spi_sel_o), 32'(exp_gnt[1]));
    check({tag, "_tx"},    32'(spi_tx_o), 32'(exp_tx));
    check({tag, "_nogntbusy"}, 32'(gnt_o), 32'h0);
    step();
    check({tag, "_start_off"}, 32'(spi_start_o), 32'h0);
    repeat (wait_n) step();
    spi_done_i = 1'b1;
    spi_rx_i   = rx;
    step();
    spi_done_i = 1'b0;
    spi_rx_i   = 16'h0;
    #1;
    check({tag, "_done"}, 32'(done_o), 32'(exp_gnt));
    check({tag, "_rx"},   32'(rx_data_o), 32'(rx));
    check({tag, "_err"},  32'(err_o), 32'h0);
    check({tag, "_txres"}, 32'(spi_tx_o), 32'(exp_tx));
    step();
    check({tag, "_done_off"}, 32'(done_o), 32'h0);
    check({tag, "_idle"},     32'(busy_o), 32'h0);
    $display("[TB] %s: req=%b gnt=%b tx=%h rx=%h", tag, req, exp_gnt, exp_tx, rx);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i    = 1'b1;
    req_i      = 2'b00;
    tx0_i      = 16'hA5A5;
    tx1_i      = 16'h5A5A;
    spi_done_i = 1'b0;
    spi_rx_i   = 16'h0;
    repeat (3) step();
    reset_i = 1'b0;
    #1;
    check_reset_vals("rst");
    $display("[TB] reset checked");

    // Single request, strobe 5 cycles after start
    xfer("single", 2'b01, 2'b01, 16'hA5A5, 4, 16'h1234, 1'b0);
    check("single_rx_hold", 32'(rx_data_o), 32'h1234);

    // Ties after reset alternate starting with requester 0
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    xfer("tie0", 2'b11, 2'b01, 16'hA5A5, 1, 16'h0101, 1'b1);
    xfer("tie1", 2'b11, 2'b10, 16'h5A5A, 0, 16'h0202, 1'b1);
    xfer("tie2", 2'b11, 2'b01, 16'hA5A5, 2, 16'h0303, 1'b1);
    xfer("tie3", 2'b11, 2'b10, 16'h5A5A, 0, 16'h0404, 1'b0);

    // Request 1 raised while busy is held off until IDLE
    req_i = 2'b01;
    #1;
    check("hold_gnt0", 32'(gnt_o), 32'h1);
    step();
    req_i = 2'b00;
    step();
    req_i = 2'b10;
    #1;
    check("hold_wait_gnt", 32'(gnt_o), 32'h0);
    step();
    check("hold_wait_gnt2", 32'(gnt_o), 32'h0);
    spi_done_i = 1'b1;
    spi_rx_i   = 16'hBEEF;
    step();
    spi_done_i = 1'b0;
    check("hold_resp_gnt", 32'(gnt_o), 32'h0);
    check("hold_resp_done", 32'(done_o), 32'h1);
    step();
    check("hold_idle_gnt", 32'(gnt_o), 32'h2);
    $display("[TB] held-off request granted after IDLE");
    xfer("hold1", 2'b10, 2'b10, 16'h5A5A, 0, 16'hCAFE, 1'b0);

    // Stray strobes in IDLE and START are ignored
    spi_done_i = 1'b1;
    spi_rx_i   = 16'hDEAD;
    step();
    check("stray_idle_busy", 32'(busy_o), 32'h0);
    check("stray_idle_done", 32'(done_o), 32'h0);
    req_i = 2'b01;
    step();
    req_i = 2'b00;
    check("stray_start_done", 32'(done_o), 32'h0);
    step();
    spi_done_i = 1'b0;
    step();
    check("stray_wait_busy", 32'(busy_o), 32'h1);
    check("stray_wait_done", 32'(done_o), 32'h0);
    check("stray_rx_kept", 32'(rx_data_o), 32'hCAFE);
    spi_done_i = 1'b1;
    spi_rx_i   = 16'h7777;
    step();
    spi_done_i = 1'b0;
    check("stray_done", 32'(done_o), 32'h1);
    step();
    $display("[TB] stray strobes ignored");

    // Reset mid-WAIT (last owner was 0, so a tie would otherwise go to 1)
    req_i = 2'b01;
    step();
    req_i = 2'b00;
    step();
    step();
    check("midrst_busy_pre", 32'(busy_o), 32'h1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check_reset_vals("midrst");
    xfer("midrst_tie", 2'b11, 2'b01, 16'hA5A5, 0, 16'h4242, 1'b0);

    // Missing strobe from the SPI master
    req_i = 2'b10;
    step();
    req_i = 2'b00;
    step();
`ifdef ARB_TIMEOUT_EN
    repeat (7) step();
    check("to_pre_done", 32'(done_o), 32'h0);
    step();
    check("to_done", 32'(done_o), 32'h2);
    check("to_err",  32'(err_o), 32'h1);
    check("to_rx",   32'(rx_data_o), 32'hFFFF);
    step();
    check("to_err_off", 32'(err_o), 32'h0);
    check("to_idle",    32'(busy_o), 32'h0);
`else
    repeat (20) step();
    check("nto_busy", 32'(busy_o), 32'h1);
    check("nto_done", 32'(done_o), 32'h0);
    check("nto_err",  32'(err_o), 32'h0);
    spi_done_i = 1'b1;
    spi_rx_i   = 16'h9999;
    step();
    spi_done_i = 1'b0;
    check("nto_late_done", 32'(done_o), 32'h2);
    step();
`endif
    $display("[TB] missing-strobe case checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
